// File: rtl/pri_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pri_pkg
// Purpose  : Shared sizes and FSM state encoding for the priority-mixer
//            shadow loader.
// Contents : PRI_NREG - number of mixer control bytes
//            PRI_AW   - mixer register index width
//            pri_state_t - commit FSM states
// Revision : 1.0 - initial release
// ============================================================================
package pri_pkg;

    localparam int PRI_NREG = 16;
    localparam int PRI_AW   = 4;

    typedef enum logic [1:0] {
        PRI_IDLE  = 2'd0,
        PRI_SCAN  = 2'd1,
        PRI_WRITE = 2'd2,
        PRI_GAP   = 2'd3
    } pri_state_t;

endpackage
`default_nettype wire

// File: rtl/pri_ffs.sv
`default_nettype none
// ============================================================================
// Module   : pri_ffs
// Purpose  : Combinational lowest-set-bit finder with a lower bound.
//            Bits of the mask below i_start are ignored, so a start of
//            PRI_NREG never produces a hit.
// Ports    : i_mask  [15:0] candidate bits
//            i_start [4:0]  first index considered (0..16)
//            o_hit          a qualifying bit exists
//            o_idx   [3:0]  index of the lowest qualifying bit (0 if no hit)
// Revision : 1.0 - initial release
// ============================================================================
module pri_ffs
    import pri_pkg::*;
(
    input  logic [PRI_NREG-1:0] i_mask,
    input  logic [PRI_AW:0]     i_start,
    output logic                o_hit,
    output logic [PRI_AW-1:0]   o_idx
);

    // Descending walk: the last qualifying bit written is the lowest one.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = PRI_NREG - 1; i >= 0; i--) begin
            if (i_mask[i] && ((PRI_AW+1)'(i) >= i_start)) begin
                o_hit = 1'b1;
                o_idx = PRI_AW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pri_shadow_loader.sv
`default_nettype none
// ============================================================================
// Module   : pri_shadow_loader
// Purpose  : Double-buffers CPU writes to the 16-byte priority-mixer control
//            bank. Writes land in a shadow bank and set a dirty bit; at the
//            start of vblank (or on flush) only the dirty bytes are replayed
//            into the mixer in ascending address order.
// Ports    : clk, reset                 clock, synchronous active-high reset
//            cs, cpu_addr, cpu_rw,      68k-side shadow bank access
//            cpu_ds_n, cpu_din, cpu_dout  (cpu_dout registered, 1-cycle read)
//            vblank                     level vblank, rising edge starts a pass
//            flush                      pulse: mark all bytes dirty and start
//            busy                       commit pass in progress
//            pri_cs, pri_addr, pri_rw,  registered mixer byte-write strobe
//            pri_ds_n, pri_dout
// Params   : WRITE_GAP - idle cycles after each mixer strobe (0..15)
// Revision : 1.0 - initial release
// ============================================================================
module pri_shadow_loader
    import pri_pkg::*;
#(
    parameter int WRITE_GAP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic [3:0] cpu_addr,
    input  logic       cpu_rw,
    input  logic [1:0] cpu_ds_n,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    input  logic       vblank,
    input  logic       flush,
    output logic       busy,
    output logic       pri_cs,
    output logic [3:0] pri_addr,
    output logic       pri_rw,
    output logic [1:0] pri_ds_n,
    output logic [7:0] pri_dout
);

    // Last GAP count value before returning to SCAN.
    localparam logic [3:0] c_gap_last = 4'((WRITE_GAP > 0) ? (WRITE_GAP - 1) : 0);

    logic [7:0]          r_shadow [PRI_NREG];
    logic [PRI_NREG-1:0] r_dirty;
    pri_state_t          r_state;
    logic [PRI_AW:0]     r_ptr;        // one extra bit so it can saturate at 16
    logic [PRI_AW-1:0]   r_idx;
    logic [3:0]          r_gap_cnt;
    logic                r_vblank;
    logic                r_busy;
    logic [7:0]          r_cpu_dout;
    logic                r_pri_cs;
    logic [3:0]          r_pri_addr;
    logic [1:0]          r_pri_ds_n;
    logic [7:0]          r_pri_dout;

    pri_state_t          w_state_nxt;
    logic [PRI_NREG-1:0] w_dirty_nxt;
    logic                w_strobe;
    logic                w_start;
    logic                w_cpu_wr;
    logic                w_cpu_rd;
    logic                w_hit;
    logic [PRI_AW-1:0]   w_hit_idx;

    // Only the low byte lane exists on this bank.
    logic                w_unused_ds_hi;
    assign w_unused_ds_hi = cpu_ds_n[1];

    assign w_cpu_wr = cs & ~cpu_rw & ~cpu_ds_n[0];
    assign w_cpu_rd = cs & cpu_rw;
    assign w_start  = (vblank & ~r_vblank) | flush;

    pri_ffs u_ffs (
        .i_mask  (r_dirty),
        .i_start (r_ptr),
        .o_hit   (w_hit),
        .o_idx   (w_hit_idx)
    );

    // ------------------------------------------------------------------------
    // Next-state and dirty-mask update. Order matters for the dirty mask:
    // the commit clear is applied first so that a flush or a same-cycle CPU
    // write to the byte being committed leaves its dirty bit set.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_strobe    = 1'b0;
        w_dirty_nxt = r_dirty;

        case (r_state)
            PRI_IDLE: begin
                if (w_start) begin
                    w_state_nxt = PRI_SCAN;
                end
            end
            PRI_SCAN: begin
                w_state_nxt = w_hit ? PRI_WRITE : PRI_IDLE;
            end
            PRI_WRITE: begin
                w_strobe    = 1'b1;
                w_state_nxt = (WRITE_GAP > 0) ? PRI_GAP : PRI_SCAN;
            end
            PRI_GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_state_nxt = PRI_SCAN;
                end
            end
            default: begin
                w_state_nxt = PRI_IDLE;
            end
        endcase

        if (w_strobe) begin
            w_dirty_nxt[r_idx] = 1'b0;
        end
        if (flush) begin
            w_dirty_nxt = '1;
        end
        if (w_cpu_wr) begin
            w_dirty_nxt[cpu_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PRI_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Shadow bank, dirty mask, pass bookkeeping and registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PRI_NREG; i++) begin
                r_shadow[i] <= '0;
            end
            r_dirty    <= '0;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_gap_cnt  <= '0;
            r_vblank   <= 1'b0;
            r_busy     <= 1'b0;
            r_cpu_dout <= '0;
            r_pri_cs   <= 1'b0;
            r_pri_addr <= '0;
            r_pri_ds_n <= 2'b11;
            r_pri_dout <= '0;
        end else begin
            r_vblank <= vblank;
            r_dirty  <= w_dirty_nxt;

            if (w_cpu_wr) begin
                r_shadow[cpu_addr] <= cpu_din;
            end
            if (w_cpu_rd) begin
                r_cpu_dout <= r_shadow[cpu_addr];
            end

            case (r_state)
                PRI_IDLE: begin
                    if (w_start) begin
                        r_ptr  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                PRI_SCAN: begin
                    if (w_hit) begin
                        r_idx <= w_hit_idx;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                PRI_WRITE: begin
                    // idx 15 yields ptr 16, which ends the pass with no wrap.
                    r_ptr     <= {1'b0, r_idx} + 5'd1;
                    r_gap_cnt <= '0;
                end
                PRI_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 4'd1;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase

            // Data is the shadow value before any same-cycle CPU write lands.
            r_pri_cs   <= w_strobe;
            r_pri_ds_n <= w_strobe ? 2'b10 : 2'b11;
            if (w_strobe) begin
                r_pri_addr <= r_idx;
                r_pri_dout <= r_shadow[r_idx];
            end
        end
    end

    assign cpu_dout = r_cpu_dout;
    assign busy     = r_busy;
    assign pri_cs   = r_pri_cs;
    assign pri_addr = r_pri_addr;
    assign pri_rw   = 1'b0;
    assign pri_ds_n = r_pri_ds_n;
    assign pri_dout = r_pri_dout;

endmodule
`default_nettype wire

// File: tb/tb_pri_shadow_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pri_shadow_loader
// Purpose  : Self-checking bench for pri_shadow_loader: CPU access table,
//            directed multi-cycle commit scenarios and a randomized phase
//            checked against a byte-array/dirty-set reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pri_shadow_loader;

    localparam int WRITE_GAP = 2;
    localparam int SPACING   = 2 + WRITE_GAP;  // cycles between strobes
    localparam int LATENCY   = 2;              // start edge -> strobe visible

    logic       clk = 1'b0;
    logic       reset, cs, cpu_rw, vblank, flush;
    logic [3:0] cpu_addr;
    logic [1:0] cpu_ds_n;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       busy, pri_cs, pri_rw;
    logic [3:0] pri_addr;
    logic [1:0] pri_ds_n;
    logic [7:0] pri_dout;

    always #5 clk = ~clk;

    pri_shadow_loader #(.WRITE_GAP(WRITE_GAP)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .cpu_addr (cpu_addr),
        .cpu_rw   (cpu_rw),
        .cpu_ds_n (cpu_ds_n),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .vblank   (vblank),
        .flush    (flush),
        .busy     (busy),
        .pri_cs   (pri_cs),
        .pri_addr (pri_addr),
        .pri_rw   (pri_rw),
        .pri_ds_n (pri_ds_n),
        .pri_dout (pri_dout)
    );

    typedef struct {
        int         cyc;
        logic [3:0] a;
        logic [7:0] d;
    } strobe_t;

    typedef struct {
        logic       cs;
        logic       rw;
        logic [1:0] ds_n;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] exp_dout;
    } vec_t;

    strobe_t sq[$];
    strobe_t mon_s;
    int      cyc       = 0;
    int      proto_err = 0;
    int      n_vec     = 0;
    int      n_err     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (pri_cs === 1'b1) begin
            mon_s.cyc = cyc;
            mon_s.a   = pri_addr;
            mon_s.d   = pri_dout;
            sq.push_back(mon_s);
        end
        if (pri_rw !== 1'b0) proto_err++;
        if (pri_ds_n !== ((pri_cs === 1'b1) ? 2'b10 : 2'b11)) proto_err++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        cs       = 1'b0;
        cpu_rw   = 1'b1;
        cpu_ds_n = 2'b11;
        cpu_addr = 4'd0;
        cpu_din  = 8'd0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        vblank = 1'b0;
        flush  = 1'b0;
        idle_bus();
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        cs = 1'b1; cpu_rw = 1'b0; cpu_ds_n = 2'b00; cpu_addr = a; cpu_din = d;
        tick();
        idle_bus();
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
        cs = 1'b1; cpu_rw = 1'b1; cpu_ds_n = 2'b00; cpu_addr = a;
        tick();
        d = cpu_dout;
        idle_bus();
    endtask

    task automatic pulse_vblank(output int t);
        vblank = 1'b1;
        tick();
        t = cyc;
        vblank = 1'b0;
    endtask

    task automatic pulse_flush(output int t);
        flush = 1'b1;
        tick();
        t = cyc;
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
        repeat (2) tick();
    endtask

    task automatic wait_strobes(input int k, input string name);
        int n = 0;
        while (sq.size() < k && n < 400) begin
            tick();
            n++;
        end
        check(name, {31'd0, (sq.size() >= k)}, 32'd1);
    endtask

    // Compare captured strobes against an expected list (address, data, timing).
    task automatic check_pass(input string name, input strobe_t exp_q[$], input int t0);
        check($sformatf("%s_count", name), sq.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < sq.size(); j++) begin
            check($sformatf("%s_addr[%0d]", name, j), {28'd0, sq[j].a}, {28'd0, exp_q[j].a});
            check($sformatf("%s_data[%0d]", name, j), {24'd0, sq[j].d}, {24'd0, exp_q[j].d});
            check($sformatf("%s_time[%0d]", name, j), sq[j].cyc - t0, LATENCY + j * SPACING);
        end
    endtask

    vec_t       tbl[12];
    strobe_t    exp_q[$];
    strobe_t    e;
    logic [7:0] rv;
    logic [7:0] m_sh[16];
    logic       m_dirty[16];
    logic [7:0] m_dout;
    int         t0, r, cnt2;
    logic [3:0] ra;
    logic [7:0] rdat;
    logic [1:0] rds;
    logic       rc;

    initial begin
        do_reset();

        // ---------------- reset state ----------------
        check("rst_cpu_dout", {24'd0, cpu_dout}, 32'h00);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_pri_cs",   {31'd0, pri_cs},   32'd0);
        check("rst_pri_addr", {28'd0, pri_addr}, 32'd0);
        check("rst_pri_ds_n", {30'd0, pri_ds_n}, 32'd3);
        check("rst_pri_dout", {24'd0, pri_dout}, 32'h00);

        // ---------------- CPU access table ----------------
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 4'd3,  8'h3C, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 2'b00, 4'd3,  8'h00, 8'h3C};
        tbl[2]  = '{1'b1, 1'b0, 2'b01, 4'd3,  8'hFF, 8'h3C};  // low strobe off
        tbl[3]  = '{1'b1, 1'b1, 2'b00, 4'd3,  8'h00, 8'h3C};
        tbl[4]  = '{1'b0, 1'b0, 2'b00, 4'd7,  8'hA5, 8'h3C};  // not selected
        tbl[5]  = '{1'b1, 1'b1, 2'b11, 4'd7,  8'h00, 8'h00};
        tbl[6]  = '{1'b1, 1'b0, 2'b10, 4'd7,  8'h5A, 8'h00};  // low lane only
        tbl[7]  = '{1'b1, 1'b1, 2'b00, 4'd7,  8'h00, 8'h5A};
        tbl[8]  = '{1'b0, 1'b1, 2'b00, 4'd3,  8'h00, 8'h5A};
        tbl[9]  = '{1'b1, 1'b0, 2'b00, 4'd15, 8'h81, 8'h5A};
        tbl[10] = '{1'b1, 1'b1, 2'b00, 4'd15, 8'h00, 8'h81};
        tbl[11] = '{1'b1, 1'b1, 2'b00, 4'd0,  8'h00, 8'h00};
        for (int i = 0; i < 12; i++) begin
            cs = tbl[i].cs; cpu_rw = tbl[i].rw; cpu_ds_n = tbl[i].ds_n;
            cpu_addr = tbl[i].a; cpu_din = tbl[i].d;
            tick();
            idle_bus();
            check($sformatf("tbl_dout[%0d]", i), {24'd0, cpu_dout}, {24'd0, tbl[i].exp_dout});
        end

        // ---------------- 1: two dirty bytes ----------------
        do_reset();
        cpu_write(4'd4, 8'h21);
        cpu_write(4'd6, 8'h43);
        sq.delete();
        pulse_vblank(t0);
        check("t1_busy_rise", {31'd0, busy}, 32'd1);
        wait_idle("t1_idle");
        exp_q.delete();
        e.cyc = 0; e.a = 4'd4; e.d = 8'h21; exp_q.push_back(e);
        e.a = 4'd6; e.d = 8'h43; exp_q.push_back(e);
        check_pass("t1", exp_q, t0);
        sq.delete();
        exp_q.delete();
        pulse_vblank(t0);
        wait_idle("t1b_idle");
        check_pass("t1_clean", exp_q, t0);

        // ---------------- 2: flush replays all 16 ----------------
        for (int i = 0; i < 16; i++) cpu_write(4'(i), 8'(i * 16));
        sq.delete();
        pulse_flush(t0);
        wait_idle("t2_idle");
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            e.a = 4'(i); e.d = 8'(i * 16); exp_q.push_back(e);
        end
        check_pass("t2", exp_q, t0);

        // ---------------- 3: write behind the pointer ----------------
        sq.delete();
        pulse_flush(t0);
        wait_strobes(3, "t3_wait");
        cpu_write(4'd2, 8'hAA);
        wait_idle("t3_idle");
        check("t3_count", sq.size(), 16);
        cnt2 = 0;
        foreach (sq[j]) if (sq[j].a == 4'd2) cnt2++;
        check("t3_addr2_once", cnt2, 1);
        check("t3_addr2_old", {24'd0, sq[2].d}, 32'h20);
        sq.delete();
        exp_q.delete();
        e.a = 4'd2; e.d = 8'hAA; exp_q.push_back(e);
        pulse_vblank(t0);
        wait_idle("t3b_idle");
        check_pass("t3_deferred", exp_q, t0);

        // ---------------- 4: write in the WRITE(5) cycle ----------------
        sq.delete();
        pulse_flush(t0);
        // WRITE(5) is the cycle that ends at edge t0+LATENCY+5*SPACING.
        while (cyc < t0 + LATENCY + 5 * SPACING - 1) tick();
        cpu_write(4'd5, 8'h77);
        wait_idle("t4_idle");
        check("t4_count", sq.size(), 16);
        check("t4_old_value", {24'd0, sq[5].d}, 32'h50);
        sq.delete();
        exp_q.delete();
        e.a = 4'd5; e.d = 8'h77; exp_q.push_back(e);
        pulse_vblank(t0);
        wait_idle("t4b_idle");
        check_pass("t4_next", exp_q, t0);

        // ---------------- 5: reset mid-pass ----------------
        sq.delete();
        pulse_flush(t0);
        wait_strobes(3, "t5_wait");
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("t5_busy",     {31'd0, busy},     32'd0);
        check("t5_cpu_dout", {24'd0, cpu_dout}, 32'h00);
        check("t5_pri_cs",   {31'd0, pri_cs},   32'd0);
        repeat (100) tick();
        check("t5_no_more_strobes", sq.size(), 3);
        cpu_read(4'd0, rv);  check("t5_rd0",  {24'd0, rv}, 32'h00);
        cpu_read(4'd5, rv);  check("t5_rd5",  {24'd0, rv}, 32'h00);
        cpu_read(4'd15, rv); check("t5_rd15", {24'd0, rv}, 32'h00);
        pulse_vblank(t0);
        wait_idle("t5_idle");
        check("t5_dirty_clear", sq.size(), 3);

        // ---------------- 6: readback and held vblank ----------------
        cpu_write(4'd9, 8'h5C);
        check("t6_hold", {24'd0, cpu_dout}, 32'h00);
        cpu_read(4'd9, rv);
        check("t6_read9", {24'd0, rv}, 32'h5C);
        sq.delete();
        vblank = 1'b1;
        t0 = cyc + 1;
        repeat (1000) tick();
        vblank = 1'b0;
        wait_idle("t6_idle");
        exp_q.delete();
        e.a = 4'd9; e.d = 8'h5C; exp_q.push_back(e);
        check_pass("t6_one_pass", exp_q, t0);

        // ---------------- randomized phase ----------------
        do_reset();
        for (int i = 0; i < 16; i++) begin
            m_sh[i] = 8'h00;
            m_dirty[i] = 1'b0;
        end
        m_dout = 8'h00;
        for (int it = 0; it < 400; it++) begin
            r    = $urandom_range(0, 99);
            ra   = 4'($urandom);
            rdat = 8'($urandom);
            rds  = 2'($urandom);
            rc   = ($urandom_range(0, 9) != 0);
            if (r < 40) begin
                cs = rc; cpu_rw = 1'b0; cpu_ds_n = rds; cpu_addr = ra; cpu_din = rdat;
                tick();
                idle_bus();
                if (rc && !rds[0]) begin
                    m_sh[ra]    = rdat;
                    m_dirty[ra] = 1'b1;
                end
                check("rnd_wr_hold", {24'd0, cpu_dout}, {24'd0, m_dout});
            end else if (r < 85) begin
                cs = rc; cpu_rw = 1'b1; cpu_ds_n = rds; cpu_addr = ra;
                tick();
                idle_bus();
                if (rc) m_dout = m_sh[ra];
                check("rnd_rd", {24'd0, cpu_dout}, {24'd0, m_dout});
            end else begin
                if (r >= 97) for (int i = 0; i < 16; i++) m_dirty[i] = 1'b1;
                exp_q.delete();
                for (int i = 0; i < 16; i++) begin
                    if (m_dirty[i]) begin
                        e.a = 4'(i); e.d = m_sh[i]; exp_q.push_back(e);
                    end
                    m_dirty[i] = 1'b0;
                end
                sq.delete();
                if (r >= 97) pulse_flush(t0);
                else         pulse_vblank(t0);
                wait_idle("rnd_idle");
                check_pass("rnd_pass", exp_q, t0);
            end
        end

        check("strobe_protocol_errors", proto_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
